// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end: decodes three 64 MB regions, forwards legal transfers
// to a simple req/ack backend, and returns two-cycle ERROR responses otherwise.
module ahb_slave_if #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic        be_req,
  output logic        be_write,
  output logic [31:0] be_addr,
  output logic [31:0] be_wdata,
  output logic [2:0]  be_sel,
  input  logic        be_ack,
  input  logic [31:0] be_rdata
);

  localparam int unsigned CntW = 8;
  localparam logic [1:0] RespOkay = 2'b00;
  localparam logic [1:0] RespErr  = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR1, S_ERR2} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_q, wait_d;
  logic              be_req_q, be_req_d;
  logic              be_write_q, be_write_d;
  logic [31:0]       be_addr_q, be_addr_d;
  logic [2:0]        be_sel_q, be_sel_d;

  logic [2:0] sel_dec;
  logic       size_ok, legal, valid, take, timeout_hit;
  logic       unused_hburst;

  // Burst type is irrelevant: every beat is treated as a single transfer.
  assign unused_hburst = ^hburst;

  // Region and alignment decode of the address phase.
  always_comb begin
    sel_dec = 3'b000;
    case (haddr[31:26])
      6'h20:   sel_dec = 3'b001;
      6'h21:   sel_dec = 3'b010;
      6'h22:   sel_dec = 3'b100;
      default: sel_dec = 3'b000;
    endcase
    size_ok = 1'b0;
    case (hsize)
      3'd0:    size_ok = 1'b1;
      3'd1:    size_ok = ~haddr[0];
      3'd2:    size_ok = (haddr[1:0] == 2'b00);
      default: size_ok = 1'b0;
    endcase
  end

  assign legal       = (sel_dec != 3'b000) && size_ok;
  assign valid       = hreadyin && htrans[1];
  assign timeout_hit = (wait_q == CntW'(TIMEOUT - 1));

  // Next state and data-phase outputs.
  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    be_req_d   = 1'b0;
    be_write_d = be_write_q;
    be_addr_d  = be_addr_q;
    be_sel_d   = be_sel_q;
    hreadyout  = 1'b1;
    hresp      = RespOkay;
    hrdata     = '0;
    be_wdata   = '0;
    take       = 1'b0;

    case (state_q)
      S_IDLE: begin
        take = 1'b1;
      end
      S_BUSY: begin
        be_wdata  = hwdata;
        hreadyout = be_ack;
        // Acknowledge beats a simultaneous timeout.
        if (be_ack) begin
          if (!be_write_q) hrdata = be_rdata;
          state_d = S_IDLE;
          take    = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_ERR1;
        end else begin
          be_req_d = 1'b1;
          wait_d   = wait_q + 8'd1;
        end
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = RespErr;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        hresp   = RespErr;
        state_d = S_IDLE;
        take    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (take && valid) begin
      if (legal) begin
        state_d    = S_BUSY;
        be_req_d   = 1'b1;
        wait_d     = '0;
        be_write_d = hwrite;
        be_addr_d  = haddr;
        be_sel_d   = sel_dec;
      end else begin
        state_d = S_ERR1;
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q    <= S_IDLE;
      wait_q     <= '0;
      be_req_q   <= 1'b0;
      be_write_q <= 1'b0;
      be_addr_q  <= '0;
      be_sel_q   <= 3'b000;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      be_req_q   <= be_req_d;
      be_write_q <= be_write_d;
      be_addr_q  <= be_addr_d;
      be_sel_q   <= be_sel_d;
    end
  end

  assign be_req   = be_req_q;
  assign be_write = be_write_q;
  assign be_addr  = be_addr_q;
  assign be_sel   = be_sel_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if: table of single transfers plus hand-written
// burst, timeout, ack/timeout tie and asynchronous reset sequences.
module tb_ahb_slave_if;

  logic        hclk, hreset, hwrite, hreadyin;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic        be_req, be_write, be_ack;
  logic [31:0] be_addr, be_wdata, be_rdata;
  logic [2:0]  be_sel;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic [2:0]  sel;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  ahb_slave_if #(.TIMEOUT(16)) dut (
    .hclk(hclk), .hreset(hreset), .hwrite(hwrite), .hreadyin(hreadyin),
    .htrans(htrans), .hsize(hsize), .hburst(hburst), .haddr(haddr),
    .hwdata(hwdata), .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp),
    .be_req(be_req), .be_write(be_write), .be_addr(be_addr),
    .be_wdata(be_wdata), .be_sel(be_sel), .be_ack(be_ack), .be_rdata(be_rdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " idle be_req"}, 32'(be_req), 32'd0);
    check({tag, " idle hreadyout"}, 32'(hreadyout), 32'd1);
    check({tag, " idle hresp"}, 32'(hresp), 32'd0);
    check({tag, " idle hrdata"}, hrdata, 32'd0);
  endtask

  task automatic do_xfer(input vec_t v, input string tag);
    haddr = v.addr; hwrite = v.write; hsize = v.size;
    htrans = 2'd2; hreadyin = 1'b1; be_ack = 1'b0;
    tick();
    htrans = 2'd0; haddr = 32'h0; hwdata = v.wdata; be_rdata = v.rdata;
    if (!v.err) begin
      for (int k = 0; k <= v.delay; k++) begin
        be_ack = (k == v.delay);
        @(negedge hclk);
        check({tag, " be_req"}, 32'(be_req), 32'd1);
        check({tag, " be_addr"}, be_addr, v.addr);
        check({tag, " be_sel"}, 32'(be_sel), 32'(v.sel));
        check({tag, " be_write"}, 32'(be_write), 32'(v.write));
        if (v.write) check({tag, " be_wdata"}, be_wdata, v.wdata);
        check({tag, " hreadyout"}, 32'(hreadyout), 32'(k == v.delay));
        check({tag, " hresp"}, 32'(hresp), 32'd0);
        check({tag, " hrdata"}, hrdata, (k == v.delay && !v.write) ? v.rdata : 32'h0);
        tick();
      end
      be_ack = 1'b0;
    end else begin
      @(negedge hclk);
      check({tag, " err1 be_req"}, 32'(be_req), 32'd0);
      check({tag, " err1 hreadyout"}, 32'(hreadyout), 32'd0);
      check({tag, " err1 hresp"}, 32'(hresp), 32'd1);
      tick();
      @(negedge hclk);
      check({tag, " err2 be_req"}, 32'(be_req), 32'd0);
      check({tag, " err2 hreadyout"}, 32'(hreadyout), 32'd1);
      check({tag, " err2 hresp"}, 32'(hresp), 32'd1);
      tick();
    end
    @(negedge hclk);
    check_idle(tag);
  endtask

  initial begin
    vecs[0]  = '{32'h8400_0000, 1'b1, 3'd0, 32'h0000_0029, 32'h0,         0, 3'b010, 1'b0};
    vecs[1]  = '{32'h8400_0000, 1'b0, 3'd0, 32'h0,         32'h0000_00A5, 3, 3'b010, 1'b0};
    vecs[2]  = '{32'h8000_0004, 1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0,         1, 3'b001, 1'b0};
    vecs[3]  = '{32'h8BFF_FFFE, 1'b0, 3'd1, 32'h0,         32'h0000_1234, 0, 3'b100, 1'b0};
    vecs[4]  = '{32'h9000_0000, 1'b1, 3'd0, 32'h1111_1111, 32'h0,         0, 3'b000, 1'b1};
    vecs[5]  = '{32'h8000_0001, 1'b0, 3'd1, 32'h0,         32'h0,         0, 3'b000, 1'b1};
    vecs[6]  = '{32'h8000_0002, 1'b0, 3'd2, 32'h0,         32'h0,         0, 3'b000, 1'b1};
    vecs[7]  = '{32'h8000_0000, 1'b1, 3'd3, 32'h0,         32'h0,         0, 3'b000, 1'b1};
    vecs[8]  = '{32'h7FFF_FFFC, 1'b0, 3'd2, 32'h0,         32'h0,         0, 3'b000, 1'b1};
    vecs[9]  = '{32'h8C00_0000, 1'b0, 3'd0, 32'h0,         32'h0,         0, 3'b000, 1'b1};
    vecs[10] = '{32'h83FF_FFFF, 1'b0, 3'd0, 32'h0,         32'h0000_005A, 2, 3'b001, 1'b0};
    vecs[11] = '{32'h8800_0000, 1'b1, 3'd2, 32'hCAFE_F00D, 32'h0,         0, 3'b100, 1'b0};

    hreset = 1'b0; hwrite = 1'b0; hreadyin = 1'b1; htrans = 2'd0;
    hsize = 3'd0; hburst = 3'd0; haddr = 32'h0; hwdata = 32'h0;
    be_ack = 1'b0; be_rdata = 32'h0;
    #1 hreset = 1'b1;
    #2;
    check_idle("reset");
    check("reset be_sel", 32'(be_sel), 32'd0);
    check("reset be_addr", be_addr, 32'd0);
    check("reset be_write", 32'(be_write), 32'd0);
    tick();
    hreset = 1'b0;

    for (int i = 0; i < 12; i++) do_xfer(vecs[i], $sformatf("vec%0d", i));

    // BUSY htrans and hreadyin=0 are not sampled.
    haddr = 32'h8000_0000; hsize = 3'd2; htrans = 2'd1;
    tick();
    @(negedge hclk);
    check_idle("htrans_busy");
    htrans = 2'd2; hreadyin = 1'b0;
    tick();
    @(negedge hclk);
    check_idle("hreadyin_low");
    hreadyin = 1'b1; htrans = 2'd0;

    // Four-beat byte burst with backend always ready.
    hwrite = 1'b1; hsize = 3'd0; be_ack = 1'b1;
    haddr = 32'h8400_0000; htrans = 2'd2;
    tick();
    for (int b = 0; b < 4; b++) begin
      hwdata = 32'h10 + 32'(b);
      if (b < 3) begin
        htrans = 2'd3; haddr = 32'h8400_0000 + 32'(b + 1);
      end else begin
        htrans = 2'd0; haddr = 32'h0;
      end
      @(negedge hclk);
      check($sformatf("burst%0d be_req", b), 32'(be_req), 32'd1);
      check($sformatf("burst%0d be_addr", b), be_addr, 32'h8400_0000 + 32'(b));
      check($sformatf("burst%0d be_wdata", b), be_wdata, 32'h10 + 32'(b));
      check($sformatf("burst%0d hreadyout", b), 32'(hreadyout), 32'd1);
      tick();
    end
    be_ack = 1'b0;
    @(negedge hclk);
    check_idle("burst_end");

    // Timeout: 16 BUSY cycles, then ERR1 (late ack ignored), then ERR2.
    hwrite = 1'b0; hsize = 3'd2; haddr = 32'h8000_0000; htrans = 2'd2;
    tick();
    htrans = 2'd0;
    for (int i = 0; i <= 16; i++) begin
      if (i == 16) begin
        be_ack = 1'b1; be_rdata = 32'h0000_0BAD;
      end
      @(negedge hclk);
      check($sformatf("timeout%0d hreadyout", i), 32'(hreadyout), 32'd0);
      check($sformatf("timeout%0d be_req", i), 32'(be_req), 32'(i < 16));
      check($sformatf("timeout%0d hresp", i), 32'(hresp), (i < 16) ? 32'd0 : 32'd1);
      tick();
    end
    @(negedge hclk);
    check("timeout err2 hreadyout", 32'(hreadyout), 32'd1);
    check("timeout err2 hresp", 32'(hresp), 32'd1);
    check("timeout err2 hrdata", hrdata, 32'd0);
    check("timeout err2 be_req", 32'(be_req), 32'd0);
    tick();
    be_ack = 1'b0;
    @(negedge hclk);
    check_idle("timeout_end");

    // Ack arrives in the same cycle the counter reaches TIMEOUT-1.
    haddr = 32'h8400_0010; hsize = 3'd2; hwrite = 1'b0; htrans = 2'd2;
    tick();
    htrans = 2'd0; be_rdata = 32'h0000_0077;
    for (int i = 0; i < 16; i++) begin
      be_ack = (i == 15);
      @(negedge hclk);
      check($sformatf("tie%0d hreadyout", i), 32'(hreadyout), 32'(i == 15));
      if (i == 15) begin
        check("tie hresp", 32'(hresp), 32'd0);
        check("tie hrdata", hrdata, 32'h0000_0077);
      end
      tick();
    end
    be_ack = 1'b0;
    @(negedge hclk);
    check_idle("tie_end");

    // Asynchronous reset in the middle of a write data phase.
    haddr = 32'h8800_0000; hsize = 3'd2; hwrite = 1'b1; htrans = 2'd2;
    tick();
    htrans = 2'd0;
    #1;
    check("prereset be_req", 32'(be_req), 32'd1);
    check("prereset be_write", 32'(be_write), 32'd1);
    check("prereset hreadyout", 32'(hreadyout), 32'd0);
    #1 hreset = 1'b1;
    #1;
    check_idle("async_reset");
    check("async_reset be_write", 32'(be_write), 32'd0);
    check("async_reset be_addr", be_addr, 32'd0);
    check("async_reset be_sel", 32'(be_sel), 32'd0);
    @(negedge hclk);
    #1 hreset = 1'b0;
    do_xfer(vecs[1], "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
